// File: rtl/disp_code_pkg.sv
// disp_code_pkg: shared definitions for the door-lock display code generator.
//   - Symbol codes understood by the per-digit seven-segment decoders.
//   - Message select and FSM state enums.
//   - msg_sym(): symbol shown at a given digit position for a given message.
package disp_code_pkg;

    // Digit symbols 0..9 map straight to their numeric value.
    localparam logic [5:0] SYM_D0   = 6'd0;
    localparam logic [5:0] SYM_D1   = 6'd1;
    localparam logic [5:0] SYM_D2   = 6'd2;
    localparam logic [5:0] SYM_D3   = 6'd3;
    localparam logic [5:0] SYM_D4   = 6'd4;
    localparam logic [5:0] SYM_D5   = 6'd5;
    localparam logic [5:0] SYM_D6   = 6'd6;
    localparam logic [5:0] SYM_D7   = 6'd7;
    localparam logic [5:0] SYM_D8   = 6'd8;
    localparam logic [5:0] SYM_D9   = 6'd9;
    localparam logic [5:0] SYM_C    = 6'd10;
    localparam logic [5:0] SYM_D    = 6'd11;
    localparam logic [5:0] SYM_E    = 6'd12;
    localparam logic [5:0] SYM_L    = 6'd13;
    localparam logic [5:0] SYM_N    = 6'd14;
    localparam logic [5:0] SYM_O    = 6'd15;
    localparam logic [5:0] SYM_P    = 6'd16;
    localparam logic [5:0] SYM_S    = 6'd17;
    // Centre segment only.
    localparam logic [5:0] SYM_DASH = 6'd63;

    typedef enum logic [1:0] {
        MSG_NONE  = 2'd0,
        MSG_OPEN  = 2'd1,
        MSG_CLOSE = 2'd2,
        MSG_NOPE  = 2'd3
    } msg_e;

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_MSG   = 1'b1
    } state_e;

    // Messages are right-aligned: digit 0 holds the last letter.
    function automatic logic [5:0] msg_sym(msg_e msg, int unsigned idx);
        logic [5:0] sym;
        sym = SYM_DASH;
        case (msg)
            MSG_OPEN: begin
                case (idx)
                    3:       sym = SYM_O;
                    2:       sym = SYM_P;
                    1:       sym = SYM_E;
                    0:       sym = SYM_N;
                    default: sym = SYM_DASH;
                endcase
            end
            MSG_CLOSE: begin
                case (idx)
                    4:       sym = SYM_C;
                    3:       sym = SYM_L;
                    2:       sym = SYM_O;
                    1:       sym = SYM_S;
                    0:       sym = SYM_E;
                    default: sym = SYM_DASH;
                endcase
            end
            MSG_NOPE: begin
                case (idx)
                    3:       sym = SYM_N;
                    2:       sym = SYM_O;
                    1:       sym = SYM_P;
                    0:       sym = SYM_E;
                    default: sym = SYM_DASH;
                endcase
            end
            default: sym = SYM_DASH;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tick_div.sv
// tick_div: free-running cycle divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count from 0 (dominates en)
//   en         : count while high; the count is held at 0 while low
//   tick       : high for one cycle every CYC enabled cycles
module tick_div #(
    parameter int unsigned CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned W    = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [W-1:0] LAST = W'(CYC - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Tick is decoded from the count so the owner can act on it in the same
    // cycle the count wraps; the count never passes LAST.
    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_msg_gen.sv
// disp_msg_gen: symbol code generator for the six-digit door-lock display.
// Buffers keypad digits and overlays timed, blinking status messages.
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_valid   : keypad strobe, key_code (0..9 accepted) valid with it
//   key_clr     : clear the entry buffer
//   msg_valid   : message request strobe, msg_sel 1=OPEN 2=CLOSE 3=NOPE
//   dig_code    : registered 6-bit symbol per digit, digit 0 rightmost
//   entry_cnt   : number of buffered digits
//   entry_full  : buffer holds MAX_ENTRY digits
//   busy        : a message is on screen
module disp_msg_gen
    import disp_code_pkg::*;
#(
    parameter int unsigned NUM_DIG   = 6,
    parameter int unsigned MAX_ENTRY = 4,
    parameter int unsigned HOLD_CYC  = 50_000_000,
    parameter int unsigned BLINK_CYC = 12_500_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    input  logic                 key_clr,
    input  logic                 msg_valid,
    input  logic [1:0]           msg_sel,
    output logic [NUM_DIG*6-1:0] dig_code,
    output logic [2:0]           entry_cnt,
    output logic                 entry_full,
    output logic                 busy
);

    state_e     state_q, state_d;
    msg_e       msg_q, msg_d;
    logic       phase_q, phase_d;   // 1 = message visible
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] buf_q [MAX_ENTRY];
    logic [3:0] buf_d [MAX_ENTRY];
    logic       busy_q, full_q;

    logic msg_go;
    logic key_ok;
    logic hold_tick;
    logic blink_tick;

    assign msg_go = msg_valid && (msg_sel != 2'd0);
    assign key_ok = key_valid && (key_code <= 4'd9) && (cnt_q < 3'(MAX_ENTRY));

    // Hold counter runs for the whole message; a new message restarts it.
    tick_div #(
        .CYC (HOLD_CYC)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (msg_go),
        .en    (state_q == ST_MSG),
        .tick  (hold_tick)
    );

    // Blink counter stops in the exit cycle so it is 0 once back in ENTRY.
    tick_div #(
        .CYC (BLINK_CYC)
    ) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (msg_go),
        .en    ((state_q == ST_MSG) && !hold_tick),
        .tick  (blink_tick)
    );

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (msg_go) begin
            // A message request beats any keypad activity in the same cycle.
            state_d = ST_MSG;
            msg_d   = msg_e'(msg_sel);
            phase_d = 1'b1;
            cnt_d   = 3'd0;
        end else if (state_q == ST_MSG) begin
            if (hold_tick) begin
                state_d = ST_ENTRY;
                phase_d = 1'b1;
            end else if (blink_tick) begin
                phase_d = ~phase_q;
            end
        end else if (key_clr) begin
            cnt_d = 3'd0;
        end else if (key_ok) begin
            buf_d[0] = key_code;
            for (int i = 1; i < int'(MAX_ENTRY); i++) begin
                buf_d[i] = buf_q[i-1];
            end
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ENTRY;
            msg_q   <= MSG_NONE;
            phase_q <= 1'b1;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            for (int i = 0; i < int'(MAX_ENTRY); i++) begin
                buf_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_MSG);
            full_q  <= (cnt_d == 3'(MAX_ENTRY));
            buf_q   <= buf_d;
        end
    end

    // Per-digit symbol selection, computed from next-state values so the
    // registered code lines up with busy and entry_cnt.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_dig
            logic [5:0] ent_sym;
            logic [5:0] sym_d;
            logic [5:0] sym_q;

            if (gi < MAX_ENTRY) begin : g_buf
                assign ent_sym = (cnt_d > 3'(gi)) ? {2'b00, buf_d[gi]} : SYM_DASH;
            end else begin : g_dash
                assign ent_sym = SYM_DASH;
            end

            always_comb begin
                sym_d = ent_sym;
                if (state_d == ST_MSG) begin
                    sym_d = phase_d ? msg_sym(msg_d, gi) : SYM_DASH;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sym_q <= SYM_DASH;
                end else begin
                    sym_q <= sym_d;
                end
            end

            assign dig_code[6*gi +: 6] = sym_q;
        end
    endgenerate

    assign entry_cnt  = cnt_q;
    assign entry_full = full_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_disp_msg_gen.sv
module tb_disp_msg_gen;

    localparam int HOLD  = 20;
    localparam int BLINK = 4;
    localparam int MAXE  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_clr;
    logic        msg_valid;
    logic [1:0]  msg_sel;
    logic [35:0] dig_code;
    logic [2:0]  entry_cnt;
    logic        entry_full;
    logic        busy;

    disp_msg_gen #(
        .NUM_DIG   (6),
        .MAX_ENTRY (MAXE),
        .HOLD_CYC  (HOLD),
        .BLINK_CYC (BLINK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_clr    (key_clr),
        .msg_valid  (msg_valid),
        .msg_sel    (msg_sel),
        .dig_code   (dig_code),
        .entry_cnt  (entry_cnt),
        .entry_full (entry_full),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] dig;
        logic        busy;
        logic [2:0]  cnt;
        logic        full;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Reference model state
    int m_busy, m_msg, m_hold, m_blk, m_on, m_cnt;
    int m_digits[MAXE];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_msg = 0; m_hold = 0; m_blk = 0; m_on = 1; m_cnt = 0;
        for (int i = 0; i < MAXE; i++) m_digits[i] = 0;
    endtask

    task automatic model_step(input int kv, input int kc, input int kclr, input int mv, input int ms);
        if (mv != 0 && ms != 0) begin
            m_busy = 1; m_msg = ms; m_hold = 0; m_blk = 0; m_on = 1; m_cnt = 0;
        end else if (m_busy != 0) begin
            if (m_hold == HOLD - 1) begin
                m_busy = 0; m_cnt = 0;
            end else begin
                m_hold++;
                m_blk++;
                if (m_blk == BLINK) begin
                    m_blk = 0;
                    m_on  = (m_on != 0) ? 0 : 1;
                end
            end
        end else if (kclr != 0) begin
            m_cnt = 0;
        end else if (kv != 0 && kc <= 9 && m_cnt < MAXE) begin
            for (int i = MAXE - 1; i > 0; i--) m_digits[i] = m_digits[i-1];
            m_digits[0] = kc;
            m_cnt++;
        end
    endtask

    function automatic logic [35:0] model_dig();
        logic [35:0] v;
        v = {6{6'd63}};
        if (m_busy != 0) begin
            if (m_on != 0) begin
                case (m_msg)
                    1: v = {6'd63, 6'd63, 6'd15, 6'd16, 6'd12, 6'd14};
                    2: v = {6'd63, 6'd10, 6'd13, 6'd15, 6'd17, 6'd12};
                    3: v = {6'd63, 6'd63, 6'd14, 6'd15, 6'd16, 6'd12};
                    default: v = {6{6'd63}};
                endcase
            end
        end else begin
            for (int i = 0; i < m_cnt; i++) v[6*i +: 6] = 6'(m_digits[i]);
        end
        return v;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.dig  = model_dig();
        e.busy = (m_busy != 0);
        e.cnt  = 3'(m_cnt);
        e.full = (m_cnt == MAXE);
        return e;
    endfunction

    // Called at a falling edge: drive one cycle of stimulus, push the model's
    // expectation, then check the DUT output at the following falling edge.
    task automatic cycle(input int kv, input int kc, input int kclr, input int mv, input int ms);
        exp_t e;
        key_valid = (kv != 0);
        key_code  = 4'(kc);
        key_clr   = (kclr != 0);
        msg_valid = (mv != 0);
        msg_sel   = 2'(ms);
        model_step(kv, kc, kclr, mv, ms);
        sb.push_back(model_exp());
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        key_clr   = 1'b0;
        msg_valid = 1'b0;
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("dig_code", 64'(dig_code), 64'(e.dig));
            chk("busy", 64'(busy), 64'(e.busy));
            chk("entry_cnt", 64'(entry_cnt), 64'(e.cnt));
            chk("entry_full", 64'(entry_full), 64'(e.full));
        end
        n_txn++;
        $display("txn %0d kv=%0d kc=%0d clr=%0d mv=%0d ms=%0d -> dig=%h busy=%0b cnt=%0d full=%0b",
                 n_txn, kv, kc, kclr, mv, ms, dig_code, busy, entry_cnt, entry_full);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_dig"}, 64'(dig_code), 64'(36'hFFFFFFFFF));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cnt"}, 64'(entry_cnt), 64'd0);
        chk({tag, "_full"}, 64'(entry_full), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0; key_clr = 1'b0;
        msg_valid = 1'b0; msg_sel = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0);

        // Entry buffer fill, overflow and invalid code
        cycle(1, 1, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        cycle(1, 3, 0, 0, 0);
        cycle(1, 4, 0, 0, 0);
        cycle(1, 5, 0, 0, 0);
        cycle(1, 11, 0, 0, 0);
        // Clear beats key
        cycle(1, 7, 1, 0, 0);
        cycle(1, 12, 0, 0, 0);
        cycle(1, 9, 0, 0, 0);
        cycle(1, 8, 0, 0, 0);
        // msg_sel 0 ignored
        cycle(0, 0, 0, 1, 0);

        // CLOSE, key in the same cycle is dropped; run through expiry
        cycle(1, 5, 0, 1, 2);
        for (int i = 0; i < HOLD + 1; i++) cycle(0, 0, 0, 0, 0);

        // OPEN with keys hammered, replaced by NOPE at cycle 10
        cycle(1, 6, 0, 0, 0);
        cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 9; i++)
            cycle(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 0, 0);
        cycle(1, 2, 0, 1, 3);
        for (int i = 0; i < HOLD + 2; i++)
            cycle(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 0, 0);

        // Message request with key_clr, then reset mid-message
        cycle(1, 3, 0, 0, 0);
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0);
        cycle(1, 6, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_msg_gen.md
Name: disp_msg_gen

Overview:
- Upstream code generator for the six-digit seven-segment display bank on the door-lock board.
- Buffers keypad digits and overlays timed status messages: OPEN, CLOSE and NOPE (wrong PIN).
- Emits one 6-bit symbol code per digit; each code feeds the display7 decoder instance for that digit.
- All outputs are registered, so the decoders see glitch-free codes.

Parameters:
- NUM_DIG, 6, number of display digits; digit 0 is the rightmost.
- MAX_ENTRY, 4, maximum number of buffered keypad digits (1..NUM_DIG).
- HOLD_CYC, 50_000_000, clock cycles a message stays on screen.
- BLINK_CYC, 12_500_000, clock cycles per blink half-period while a message is shown.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- key_valid, input, 1, one-cycle strobe; key_code is valid in that cycle.
- key_code, input, 4, keypad digit 0..9; values 10..15 are ignored.
- key_clr, input, 1, one-cycle strobe that clears the entry buffer.
- msg_valid, input, 1, one-cycle strobe requesting a message.
- msg_sel, input, 2, message select: 0 none, 1 OPEN, 2 CLOSE, 3 NOPE.
- dig_code, output, NUM_DIG*6, symbol codes; dig_code[6*i+:6] drives digit i.
- entry_cnt, output, 3, number of buffered digits (0..MAX_ENTRY).
- entry_full, output, 1, high when entry_cnt == MAX_ENTRY.
- busy, output, 1, high while a message is displayed.

Behaviour:
- Symbol codes: 0..9 are digits; C=10, D=11, E=12, L=13, N=14, O=15, P=16, S=17; DASH=63. DASH decodes to the centre segment only.
- Reset (async, rst_n low):
  - state ENTRY; buffer empty; entry_cnt=0; entry_full=0; busy=0.
  - every dig_code field = DASH; hold and blink counters = 0.
- State ENTRY:
  - The accepted key shifts in at digit 0; older digits move up one position.
  - Digits at positions >= entry_cnt show DASH.
  - A key is accepted only when key_valid=1, key_code<=9 and entry_cnt<MAX_ENTRY. Otherwise it is dropped and nothing changes.
  - key_clr empties the buffer; the next cycle shows all DASH.
  - key_clr and key_valid in the same cycle: clear wins and the key is dropped.
- ENTRY -> MSG:
  - Triggered by msg_valid=1 with msg_sel!=0; msg_sel=0 is ignored.
  - The message is latched, busy=1, hold counter=0, blink phase=on.
  - The entry buffer is cleared on entry to MSG.
  - msg_valid beats key_valid or key_clr in the same cycle.
- State MSG:
  - Message text is right-aligned and unused digits show DASH:
    - OPEN: digits 3..0 = O,P,E,N.
    - CLOSE: digits 4..0 = C,L,O,S,E.
    - NOPE: digits 3..0 = N,O,P,E.
  - Blink phase toggles every BLINK_CYC cycles; the off phase shows all DASH.
  - key_valid and key_clr are ignored.
  - A new valid msg_valid replaces the message and restarts both the hold and blink counters.
- MSG -> ENTRY:
  - Occurs when the hold counter reaches HOLD_CYC-1.
  - The next cycle shows all DASH, busy=0, entry_cnt=0.
- Latency: each strobe affects dig_code, busy and entry_cnt exactly one clock later.
- Counters: widths come from $clog2 of the parameter and never overflow. Both the hold and blink counters are held at 0 in ENTRY.
- Reset mid-message: immediate return to the reset values. Nothing from the previous message persists.

Decomposition:
- Package disp_code_pkg holds:
  - symbol code constants (digits, C, D, E, L, N, O, P, S, DASH);
  - the msg_sel enum (MSG_NONE, MSG_OPEN, MSG_CLOSE, MSG_NOPE);
  - the state enum (ST_ENTRY, ST_MSG);
  - a function mapping message and digit index to a symbol code.
- One sub-module, tick_div:
  - parameter CYC; ports clk, rst_n, clr, en, tick;
  - emits a one-cycle tick every CYC cycles while en=1;
  - instantiated twice, once for hold and once for blink.

Test Plan:
Benches run with HOLD_CYC=20 and BLINK_CYC=4.
- Reset release -> all six codes are 63; busy=0, entry_cnt=0, entry_full=0.
- Keys 1,2,3 -> digits 2..0 = 1,2,3 and digits 5..3 = 63; entry_cnt=3.
- Keys 4,5 -> digits 3..0 = 1,2,3,4; the 5 is dropped; entry_full=1. Then key_code=11 -> no change.
- key_clr together with key_valid (7) -> all 63, entry_cnt=0.
- msg_sel=2 -> next cycle digits 4..0 = 10,13,15,17,12 and digit 5 = 63; busy=1.
  - All codes go 63 for 4 cycles every 8.
  - After 20 cycles all 63 and busy=0.
- During OPEN, at cycle 10 msg_sel=3 -> digits 3..0 = 14,15,16,12; busy stays high for 20 more cycles; keys are ignored throughout.
